// File: rtl/vram_scan_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its game-logic requester and the VRAM macro.
// The slave modport is the arbiter's view; master is the requester plus memory side.
interface vram_scan_arbiter_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [15:0]       cpu_wdata;
    logic              cpu_ack;
    logic [15:0]       cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_scan_arbiter.sv
// Single-port VRAM arbiter: fixed scan-out fetch slots for a 2x2-doubled 320x240 8bpp
// framebuffer on an 800x525 raster, with game-logic accesses filling the remaining cycles.
module vram_scan_arbiter #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] FB_BASE  = {ADDR_W{1'b0}},
    parameter int unsigned       WORDS_PL = 160
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [15:0]          CounterX,
    input  logic [15:0]          CounterY,
    vram_scan_arbiter_if.slave   bus,
    output logic [7:0]           pix_data,
    output logic                 pix_valid
);

    // Last ph1 column that still prepares an in-line fetch (group WORDS_PL-1).
    localparam int unsigned LAST_PH1 = 4 * WORDS_PL - 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_we_r;
    logic [15:0]       mem_wdata_r;
    logic              cpu_ack_r;
    logic [15:0]       cpu_rdata_r;
    logic              fetch_d1_r;
    logic              fetch_d2_r;
    logic [15:0]       pix_word_r;
    logic [7:0]        pix_data_r;
    logic              pix_valid_r;

    logic [1:0]        ph_s;
    logic [15:0]       next_line_s;
    logic              line_fetch_s;
    logic              wrap_fetch_s;
    logic              fetch_en_s;
    logic [15:0]       fetch_line_s;
    logic [13:0]       group_s;
    logic [ADDR_W-1:0] video_row_s;
    logic [ADDR_W-1:0] video_addr_s;
    logic              cpu_go_s;
    logic              active_s;

    // Slot decode: does the next cycle belong to scan-out, and which word does it fetch.
    always_comb begin
        ph_s         = CounterX[1:0];
        next_line_s  = (CounterY == 16'd524) ? 16'd0 : (CounterY + 16'd1);
        line_fetch_s = (ph_s == 2'd1) && (CounterX <= 16'(LAST_PH1)) && (CounterY < 16'd480);
        wrap_fetch_s = (CounterX == 16'd797) && (CounterY <= 16'd524) && (next_line_s < 16'd480);
        fetch_en_s   = line_fetch_s || wrap_fetch_s;
        if (line_fetch_s) begin
            fetch_line_s = CounterY;
            group_s      = CounterX[15:2] + 14'd1;
        end else begin
            fetch_line_s = next_line_s;
            group_s      = 14'd0;
        end
        video_row_s  = ADDR_W'(fetch_line_s >> 1);
        video_addr_s = FB_BASE + (video_row_s << 7) + (video_row_s << 5) + ADDR_W'(group_s);
        cpu_go_s     = bus.cpu_req && !fetch_en_s;
        active_s     = (CounterX < 16'd640) && (CounterY < 16'd480);
    end

    // CPU handshake FSM and the registered VRAM command bus it shares with scan-out.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= ST_IDLE;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 16'd0;
            cpu_ack_r   <= 1'b0;
            cpu_rdata_r <= 16'd0;
        end else begin
            mem_we_r  <= 1'b0;
            cpu_ack_r <= 1'b0;
            if (fetch_en_s) begin
                mem_addr_r <= video_addr_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (cpu_go_s) begin
                        state_r     <= ST_ISSUE;
                        mem_addr_r  <= bus.cpu_addr;
                        mem_we_r    <= bus.cpu_we;
                        mem_wdata_r <= bus.cpu_wdata;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_we_r) begin
                        state_r   <= ST_ACK;
                        cpu_ack_r <= 1'b1;
                    end else begin
                        state_r <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    cpu_rdata_r <= bus.mem_rdata;
                    cpu_ack_r   <= 1'b1;
                    state_r     <= ST_ACK;
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Scan-out pipeline: track fetch slots to the data cycle, then emit one pixel per clock.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_d1_r  <= 1'b0;
            fetch_d2_r  <= 1'b0;
            pix_word_r  <= 16'd0;
            pix_data_r  <= 8'd0;
            pix_valid_r <= 1'b0;
        end else begin
            fetch_d1_r  <= fetch_en_s;
            fetch_d2_r  <= fetch_d1_r;
            if (fetch_d2_r) begin
                pix_word_r <= bus.mem_rdata;
            end
            pix_valid_r <= active_s;
            if (!active_s) begin
                pix_data_r <= 8'd0;
            end else if (CounterX[1]) begin
                pix_data_r <= pix_word_r[15:8];
            end else begin
                pix_data_r <= pix_word_r[7:0];
            end
        end
    end

    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.cpu_ack   = cpu_ack_r;
    assign bus.cpu_rdata = cpu_rdata_r;
    assign pix_data      = pix_data_r;
    assign pix_valid     = pix_valid_r;

endmodule
